// File: rtl/i2s_pkg.sv
// Shared types and constants for the stereo I2S capture block.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        REC
    } rec_state_t;

    localparam int MODE_LJ  = 0;
    localparam int MODE_I2S = 1;

    localparam logic [5:0] BIT_IDX_MAX = 6'd63;

endpackage

// File: rtl/sync_fifo.sv
// Frame FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == CNT_FULL);
    assign o_empty = (count == '0);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!full || do_pop);
    assign o_drop  = i_push && !do_push;
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_stereo_recorder.sv
// Stereo I2S capture: synchronises the codec pins, deserialises left/right slots
// and queues complete {left, right} frames for a valid/ready consumer.
module i2s_stereo_recorder
    import i2s_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int DEPTH    = 4,
    parameter int I2S_MODE = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_BCLK,
    input  logic                       i_LRCK,
    input  logic                       i_data,
    output logic signed [WIDTH-1:0]    o_left,
    output logic signed [WIDTH-1:0]    o_right,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic                       o_busy
);

    localparam int MODE_OFFSET = (I2S_MODE == MODE_I2S) ? 1 : 0;

    logic [1:0]         bclk_sync;
    logic [1:0]         lrck_sync;
    logic [1:0]         data_sync;
    logic               bclk_prev;
    logic               lrck_prev;
    logic [5:0]         bit_idx;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   left_word;
    rec_state_t         state;
    logic               push_req;
    logic [2*WIDTH-1:0] push_frame;
    logic               overflow;

    logic               bclk_rise;
    logic               lrck_s;
    logic               data_s;
    logic               slot_start;
    logic [5:0]         idx_next;
    logic [WIDTH-1:0]   shift_next;
    int                 pos;

    logic [2*WIDTH-1:0] head;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               pop;

    assign bclk_rise  = bclk_sync[1] && !bclk_prev;
    assign lrck_s     = lrck_sync[1];
    assign data_s     = data_sync[1];
    assign slot_start = (lrck_s != lrck_prev);

    // Next slot bit position and the shift word after this BCLK rise; the word restarts at each LRCK change.
    always_comb begin
        idx_next   = bit_idx;
        shift_next = shift_reg;
        if (slot_start) begin
            idx_next   = '0;
            shift_next = '0;
        end else if (bit_idx != BIT_IDX_MAX) begin
            idx_next = bit_idx + 6'd1;
        end
        pos = int'(idx_next) - MODE_OFFSET;
        for (int i = 0; i < WIDTH; i++) begin
            if (pos == WIDTH - 1 - i) begin
                shift_next[i] = data_s;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            bclk_sync <= {bclk_sync[0], i_BCLK};
            lrck_sync <= {lrck_sync[0], i_LRCK};
            data_sync <= {data_sync[0], i_data};
            bclk_prev <= bclk_sync[1];
            if (bclk_rise) begin
                lrck_prev <= lrck_s;
                bit_idx   <= idx_next;
                shift_reg <= shift_next;
            end
        end
    end

    // shift_reg still holds the slot that just closed when the LRCK change is seen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            left_word  <= '0;
            push_req   <= 1'b0;
            push_frame <= '0;
            overflow   <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
            if (i_stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            state    <= SYNC;
                            overflow <= 1'b0;
                        end
                    end
                    SYNC: begin
                        if (bclk_rise && slot_start && !lrck_s) begin
                            state <= REC;
                        end
                    end
                    REC: begin
                        if (bclk_rise && slot_start) begin
                            if (lrck_s) begin
                                left_word <= shift_reg;
                            end else begin
                                push_req   <= 1'b1;
                                push_frame <= {left_word, shift_reg};
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign pop = o_valid && i_ready;

    sync_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push_req),
        .i_data  (push_frame),
        .i_pop   (pop),
        .o_data  (head),
        .o_empty (fifo_empty),
        .o_count (o_level),
        .o_drop  (fifo_drop)
    );

    assign o_left     = head[2*WIDTH-1:WIDTH];
    assign o_right    = head[WIDTH-1:0];
    assign o_valid    = !fifo_empty;
    assign o_overflow = overflow;
    assign o_busy     = (state != IDLE);

endmodule
